// File: rtl/sram_record_playback_pkg.sv
// Shared types for the SRAM record/playback controller: FSM states and
// the encodings of the mode input.
package sram_ctrl_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_IDLE = 2'b00;
  localparam mode_t MODE_REC  = 2'b01;
  localparam mode_t MODE_PLAY = 2'b10;
  localparam mode_t MODE_LOOP = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_STROBE,
    ST_WR_RECOV,
    ST_RD_STROBE,
    ST_RD_OUT
  } state_e;

  function automatic logic isPlayMode(input mode_t m);
    return (m == MODE_PLAY) || (m == MODE_LOOP);
  endfunction

endpackage

// File: rtl/sram_record_playback_if.sv
// Bundles the MCU record handshake, the DAC playback handshake, the SRAM
// address/strobes and the status flags. The controller takes the slave view.
interface sram_record_playback_if
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19
);

  mode_t             mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [ADDR_W:0]   rec_len;
  logic              full;
  logic              busy;
  logic              done;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sram_addr, sram_ce_n, sram_oe_n,
           sram_we_n, rec_len, full, busy, done
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sram_addr, sram_ce_n, sram_oe_n,
           sram_we_n, rec_len, full, busy, done
  );

endinterface

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that times the width of an SRAM strobe; last_o is
// high on the final cycle of the strobe.
module sram_wait_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] loadVal_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = loadVal_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/sram_record_playback.sv
// Records a sample stream into an asynchronous SRAM and plays it back once
// or looped, with timed strobes and a dead cycle between write and read.
module sram_record_playback
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 19,
  parameter int WAIT_CYC   = 1,
  parameter int INVERT_MSB = 1
) (
  input  logic                clk,
  input  logic                rst,
  sram_record_playback_if.slave bus,
  inout  wire  [DATA_W-1:0]   sram_dq
);

  localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYC - 1);
  localparam logic [DATA_W-1:0] MSB_MASK =
    (INVERT_MSB != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   wrPtr_q, wrPtr_d;
  logic [ADDR_W:0]   rdPtr_q, rdPtr_d;
  logic [ADDR_W:0]   recLen_q, recLen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wrData_q, wrData_d;
  logic [DATA_W-1:0] outData_q, outData_d;
  mode_t             lastMode_q, lastMode_d;
  logic              done_q, done_d;

  logic              waitLoad;
  logic              waitLast;
  logic              inReady;
  logic              fullFlag;
  logic              driveDq;
  logic [ADDR_W:0]   rdPtrNext;

  assign fullFlag  = recLen_q[ADDR_W];
  assign rdPtrNext = rdPtr_q + 1'b1;

  // lastMode_q is the mode the controller last acted on in IDLE, so mode
  // edges (start record, start play) are seen once even across accesses.
  assign inReady = (state_q == ST_IDLE) && (bus.mode == MODE_REC) &&
                   (lastMode_q == MODE_REC) && !fullFlag;

  always_comb begin
    state_d    = state_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    recLen_d   = recLen_q;
    addr_d     = addr_q;
    wrData_d   = wrData_q;
    outData_d  = outData_q;
    lastMode_d = lastMode_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        lastMode_d = bus.mode;
        if (bus.mode == MODE_REC) begin
          if (lastMode_q != MODE_REC) begin
            wrPtr_d  = '0;
            recLen_d = '0;
          end else if (bus.in_valid && inReady) begin
            wrData_d = bus.in_data;
            addr_d   = wrPtr_q[ADDR_W-1:0];
            state_d  = ST_WR_STROBE;
          end
        end else if (isPlayMode(bus.mode) && (bus.mode != lastMode_q)) begin
          if (recLen_q == '0) begin
            done_d = 1'b1;
          end else begin
            rdPtr_d = '0;
            addr_d  = '0;
            state_d = ST_RD_STROBE;
          end
        end
      end

      ST_WR_STROBE: begin
        if (waitLast) state_d = ST_WR_RECOV;
      end

      ST_WR_RECOV: begin
        wrPtr_d  = wrPtr_q + 1'b1;
        recLen_d = wrPtr_q + 1'b1;
        state_d  = ST_IDLE;
      end

      ST_RD_STROBE: begin
        if (waitLast) begin
          outData_d = sram_dq ^ MSB_MASK;
          state_d   = ST_RD_OUT;
        end
      end

      ST_RD_OUT: begin
        if (bus.out_ready) begin
          // A mode change only takes effect once the held sample is taken.
          if (rdPtrNext == recLen_q) begin
            if ((bus.mode == MODE_LOOP) && (lastMode_q == MODE_LOOP)) begin
              rdPtr_d = '0;
              addr_d  = '0;
              state_d = ST_RD_STROBE;
            end else begin
              rdPtr_d = rdPtrNext;
              done_d  = (lastMode_q == MODE_PLAY);
              state_d = ST_IDLE;
            end
          end else if (bus.mode != lastMode_q) begin
            rdPtr_d = rdPtrNext;
            state_d = ST_IDLE;
          end else begin
            rdPtr_d = rdPtrNext;
            addr_d  = rdPtrNext[ADDR_W-1:0];
            state_d = ST_RD_STROBE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      recLen_q   <= '0;
      addr_q     <= '0;
      wrData_q   <= '0;
      outData_q  <= '0;
      lastMode_q <= MODE_IDLE;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      recLen_q   <= recLen_d;
      addr_q     <= addr_d;
      wrData_q   <= wrData_d;
      outData_q  <= outData_d;
      lastMode_q <= lastMode_d;
      done_q     <= done_d;
    end
  end

  assign waitLoad = ((state_d == ST_WR_STROBE) && (state_q != ST_WR_STROBE)) ||
                    ((state_d == ST_RD_STROBE) && (state_q != ST_RD_STROBE));

  sram_wait_counter #(
    .CNT_W (CNT_W)
  ) u_waitCounter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (waitLoad),
    .en_i      ((state_q == ST_WR_STROBE) || (state_q == ST_RD_STROBE)),
    .loadVal_i (WAIT_LOAD),
    .last_o    (waitLast)
  );

  // Strobes decode straight from the state register so an async reset
  // releases them and the data bus in the same instant.
  assign driveDq       = (state_q == ST_WR_STROBE) || (state_q == ST_WR_RECOV);
  assign sram_dq       = driveDq ? wrData_q : {DATA_W{1'bz}};

  assign bus.sram_ce_n = !((state_q == ST_WR_STROBE) || (state_q == ST_WR_RECOV) ||
                           (state_q == ST_RD_STROBE));
  assign bus.sram_we_n = (state_q != ST_WR_STROBE);
  assign bus.sram_oe_n = (state_q != ST_RD_STROBE);
  assign bus.sram_addr = addr_q;
  assign bus.in_ready  = inReady;
  assign bus.out_valid = (state_q == ST_RD_OUT);
  assign bus.out_data  = outData_q;
  assign bus.rec_len   = recLen_q;
  assign bus.full      = fullFlag;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_sram_record_playback.sv
// Directed bench for sram_record_playback with a behavioural async SRAM
// (ADDR_W=4, WAIT_CYC=2, MSB inversion on).
module tb_sram_record_playback;
  import sram_ctrl_pkg::*;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 4;
  localparam int WAIT_CYC   = 2;
  localparam int INVERT_MSB = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  wire  [DATA_W-1:0] sram_dq;
  logic [DATA_W-1:0] mem [16];

  int total = 0;
  int bad = 0;
  int busViolations = 0;
  int gap;
  int accepted;
  int doneCnt;
  int validCnt;
  int busyCnt;
  logic stalled;
  logic ready;
  logic [DATA_W-1:0] held;
  logic [DATA_W-1:0] expPlay [4] = '{8'h90, 8'hA0, 8'hB0, 8'hC0};

  sram_record_playback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sram_record_playback #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .WAIT_CYC   (WAIT_CYC),
    .INVERT_MSB (INVERT_MSB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .sram_dq (sram_dq)
  );

  always #5 clk = ~clk;

  // SRAM model: drives only while chip and output are enabled.
  assign sram_dq = (!bus.sram_ce_n && !bus.sram_oe_n) ? mem[bus.sram_addr] : 'z;

  always @(posedge clk) begin
    if (!bus.sram_ce_n && !bus.sram_we_n) mem[bus.sram_addr] <= sram_dq;
  end

  always @(posedge clk) begin
    if (!bus.sram_oe_n && !bus.sram_we_n) busViolations <= busViolations + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input mode_t mode, input logic inValid,
                               input logic [DATA_W-1:0] inData, input logic outReady);
    bus.mode      = mode;
    bus.in_valid  = inValid;
    bus.in_data   = inData;
    bus.out_ready = outReady;
  endtask

  task automatic recordSample(input logic [DATA_W-1:0] data, input int expAddr);
    int waitCnt = 0;
    applyStimulus(MODE_REC, 1'b1, data, 1'b0);
    while (!bus.in_ready && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    checkOutput("inReadyBeforeWrite", bus.in_ready, 1);
    tick();
    applyStimulus(MODE_REC, 1'b0, '0, 1'b0);
    checkOutput("weLowCycle1", bus.sram_we_n, 0);
    checkOutput("writeAddr", bus.sram_addr, expAddr);
    checkOutput("writeData", sram_dq, data);
    tick();
    checkOutput("weLowCycle2", bus.sram_we_n, 0);
    tick();
    checkOutput("weRecovHigh", bus.sram_we_n, 1);
    checkOutput("ceRecovLow", bus.sram_ce_n, 0);
    tick();
    checkOutput("busyAfterWrite", bus.busy, 0);
    checkOutput("inReadyAfterWrite", bus.in_ready, (expAddr != 15) ? 1 : 0);
  endtask

  initial begin
    applyStimulus(MODE_IDLE, 1'b0, '0, 1'b0);
    #3;
    checkOutput("rstStrobes", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}, 3'b111);
    checkOutput("rstAddr", bus.sram_addr, 0);
    checkOutput("rstInReady", bus.in_ready, 0);
    checkOutput("rstOutValid", bus.out_valid, 0);
    checkOutput("rstOutData", bus.out_data, 0);
    checkOutput("rstRecLen", bus.rec_len, 0);
    checkOutput("rstFlags", {bus.full, bus.busy, bus.done}, 3'b000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    $display("[TB] record four samples");
    recordSample(8'h10, 0);
    recordSample(8'h20, 1);
    recordSample(8'h30, 2);
    recordSample(8'h40, 3);
    checkOutput("recLen4", bus.rec_len, 4);
    checkOutput("notFull4", bus.full, 0);
    checkOutput("mem0", mem[0], 8'h10);
    checkOutput("mem3", mem[3], 8'h40);

    $display("[TB] play once");
    applyStimulus(MODE_PLAY, 1'b0, '0, 1'b1);
    gap = 0;
    for (int k = 0; k < 4; k++) begin
      while (!bus.out_valid && gap < 40) begin
        tick();
        gap++;
      end
      checkOutput("playValid", bus.out_valid, 1);
      checkOutput("playData", bus.out_data, expPlay[k]);
      if (k > 0) checkOutput("playSpacing", gap, 3);
      tick();
      gap = 1;
    end
    checkOutput("playDonePulse", bus.done, 1);
    checkOutput("playBusyEnd", bus.busy, 0);
    checkOutput("playValidEnd", bus.out_valid, 0);
    tick();
    checkOutput("playDoneCleared", bus.done, 0);
    checkOutput("playNoRestart", bus.busy, 0);

    $display("[TB] loop with backpressure");
    applyStimulus(MODE_LOOP, 1'b0, '0, 1'b0);
    accepted = 0;
    stalled = 1'b0;
    ready = 1'b0;
    held = '0;
    for (int c = 0; c < 200 && accepted < 10; c++) begin
      tick();
      if (stalled) begin
        checkOutput("loopHoldValid", bus.out_valid, 1);
        checkOutput("loopHoldData", bus.out_data, held);
      end
      ready = ~ready;
      bus.out_ready = ready;
      if (bus.out_valid && ready) begin
        checkOutput("loopData", bus.out_data, expPlay[accepted % 4]);
        accepted++;
        stalled = 1'b0;
      end else if (bus.out_valid) begin
        stalled = 1'b1;
        held = bus.out_data;
      end else begin
        stalled = 1'b0;
      end
    end
    checkOutput("loopCount", accepted, 10);
    applyStimulus(MODE_IDLE, 1'b0, '0, 1'b1);
    busyCnt = 0;
    while (bus.busy && busyCnt < 20) begin
      tick();
      busyCnt++;
    end
    checkOutput("loopStopIdle", bus.busy, 0);

    $display("[TB] play with empty recording");
    applyStimulus(MODE_REC, 1'b0, '0, 1'b1);
    tick();
    tick();
    checkOutput("emptyRecLen", bus.rec_len, 0);
    applyStimulus(MODE_PLAY, 1'b0, '0, 1'b1);
    doneCnt = 0;
    validCnt = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.done) doneCnt++;
      if (bus.out_valid) validCnt++;
    end
    checkOutput("emptyDoneOnce", doneCnt, 1);
    checkOutput("emptyNoValid", validCnt, 0);
    checkOutput("emptyNotBusy", bus.busy, 0);

    $display("[TB] fill to full");
    for (int i = 0; i < 16; i++) recordSample(8'(i * 3 + 1), i);
    checkOutput("fullFlag", bus.full, 1);
    checkOutput("fullRecLen", bus.rec_len, 16);
    checkOutput("fullInReady", bus.in_ready, 0);
    checkOutput("memLast", mem[15], 8'h2E);
    applyStimulus(MODE_REC, 1'b1, 8'hEE, 1'b0);
    busyCnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.busy) busyCnt++;
    end
    checkOutput("fullRejects", busyCnt, 0);
    checkOutput("fullRecLenKept", bus.rec_len, 16);

    $display("[TB] reset during write strobe");
    applyStimulus(MODE_IDLE, 1'b0, '0, 1'b0);
    tick();
    recordSample(8'h11, 0);
    checkOutput("preResetRecLen", bus.rec_len, 1);
    applyStimulus(MODE_REC, 1'b1, 8'h5A, 1'b0);
    gap = 0;
    while (!bus.in_ready && gap < 20) begin
      tick();
      gap++;
    end
    tick();
    applyStimulus(MODE_REC, 1'b0, '0, 1'b0);
    checkOutput("midWriteWeLow", bus.sram_we_n, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncRstStrobes", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}, 3'b111);
    checkOutput("asyncRstDqReleased", (sram_dq !== 8'h5A) ? 1 : 0, 1);
    checkOutput("asyncRstRecLen", bus.rec_len, 0);
    checkOutput("asyncRstAddr", bus.sram_addr, 0);
    checkOutput("asyncRstOutData", bus.out_data, 0);
    checkOutput("asyncRstFlags", {bus.in_ready, bus.out_valid, bus.full, bus.busy, bus.done}, 5'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    checkOutput("busOeWeExclusive", busViolations, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
